// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Purpose  : 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined)
//             with a small receive FIFO and sticky error flags.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       uart_re,
    output logic [7:0] uart_data,
    output logic       empty,
    output logic       full,
    output logic       frame_err,
    output logic       overrun,
    input  logic       clr_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int c_timer_w = $clog2(CLKS_PER_BIT);
    localparam int c_addr_w  = $clog2(FIFO_DEPTH);

    localparam logic [c_timer_w-1:0] c_half_m1 = c_timer_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_timer_w-1:0] c_full_m1 = c_timer_w'(CLKS_PER_BIT - 1);
    localparam logic [c_addr_w:0]    c_depth   = (c_addr_w + 1)'(FIFO_DEPTH);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_start  = 3'd1;
    localparam logic [2:0] c_st_data   = 3'd2;
    localparam logic [2:0] c_st_stop   = 3'd3;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] c_st_parity = 3'd4;
`endif

    logic                 r_rx_meta;
    logic                 r_rx_sync;
    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic [c_timer_w-1:0] r_timer;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_shift;
    logic                 r_push_req;
    logic [7:0]           r_push_data;

    logic w_timer_clr;
    logic w_timer_inc;
    logic w_bit_sample;
    logic w_push_req;
    logic w_ferr_set;

    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w:0]   r_count;
    logic [7:0]          r_data;
    logic                r_frame_err;
    logic                r_overrun;
    logic                w_pop;
    logic                w_push;
    logic                w_ovr_set;

`ifdef UART_RX_PARITY_EN
    logic w_perr_set;
    logic r_par_bad;
    logic r_parity_err;
`endif

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_timer_clr  = 1'b0;
        w_timer_inc  = 1'b0;
        w_bit_sample = 1'b0;
        w_push_req   = 1'b0;
        w_ferr_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_perr_set   = 1'b0;
`endif
        case (r_state)
            c_st_idle: begin
                if (!r_rx_sync) begin
                    w_state_nxt = c_st_start;
                    w_timer_clr = 1'b1;
                end
            end
            c_st_start: begin
                if (r_timer == c_half_m1) begin
                    w_timer_clr = 1'b1;
                    w_state_nxt = r_rx_sync ? c_st_idle : c_st_data;
                end else begin
                    w_timer_inc = 1'b1;
                end
            end
            c_st_data: begin
                if (r_timer == c_full_m1) begin
                    w_timer_clr  = 1'b1;
                    w_bit_sample = 1'b1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = c_st_parity;
`else
                        w_state_nxt = c_st_stop;
`endif
                    end
                end else begin
                    w_timer_inc = 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            c_st_parity: begin
                if (r_timer == c_full_m1) begin
                    w_timer_clr = 1'b1;
                    w_perr_set  = (r_rx_sync != ^r_shift);
                    w_state_nxt = c_st_stop;
                end else begin
                    w_timer_inc = 1'b1;
                end
            end
`endif
            c_st_stop: begin
                if (r_timer == c_full_m1) begin
                    w_timer_clr = 1'b1;
                    w_state_nxt = c_st_idle;
                    if (r_rx_sync) begin
`ifdef UART_RX_PARITY_EN
                        w_push_req = !r_par_bad;
`else
                        w_push_req = 1'b1;
`endif
                    end else begin
                        w_ferr_set = 1'b1;
                    end
                end else begin
                    w_timer_inc = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer     <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_push_req  <= 1'b0;
            r_push_data <= 8'h00;
        end else begin
            if (w_timer_clr) begin
                r_timer <= '0;
            end else if (w_timer_inc) begin
                r_timer <= r_timer + 1'b1;
            end
            if (r_state == c_st_idle) begin
                r_bit_idx <= 3'd0;
            end else if (w_bit_sample) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            // LSB arrives first, so shift in from the top
            if (w_bit_sample) begin
                r_shift <= {r_rx_sync, r_shift[7:1]};
            end
            r_push_req <= w_push_req;
            if (w_push_req) begin
                r_push_data <= r_shift;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (r_state == c_st_idle) begin
                r_par_bad <= 1'b0;
            end else if (w_perr_set) begin
                r_par_bad <= 1'b1;
            end
            r_parity_err <= (r_parity_err & ~clr_err) | w_perr_set;
        end
    end

    assign parity_err = r_parity_err;
`endif

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign w_pop     = uart_re & ~empty;
    assign w_push    = r_push_req & (~full | w_pop);
    assign w_ovr_set = r_push_req & full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data      <= 8'h00;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_data   <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_frame_err <= (r_frame_err & ~clr_err) | w_ferr_set;
            r_overrun   <= (r_overrun & ~clr_err) | w_ovr_set;
        end
    end

    assign uart_data = r_data;
    assign empty     = (r_count == '0);
    assign full      = (r_count == c_depth);
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_fifo
//  Purpose  : scoreboard bench for uart_rx_fifo; expected bytes are queued
//             as frames are sent and a monitor checks every pop.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int c_cpb = 16;
`ifdef UART_RX_PARITY_EN
    localparam int c_pb = 1;
`else
    localparam int c_pb = 0;
`endif
    // Edge (counted from the start bit) on which the stop bit is sampled
    localparam int c_stop_edge = 3 + c_cpb / 2 + c_cpb * (9 + c_pb);

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       uart_re;
    logic [7:0] uart_data;
    logic       empty;
    logic       full;
    logic       frame_err;
    logic       overrun;
    logic       clr_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    uart_rx_fifo #(.CLKS_PER_BIT(c_cpb), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .uart_re   (uart_re),
        .uart_data (uart_data),
        .empty     (empty),
        .full      (full),
        .frame_err (frame_err),
        .overrun   (overrun),
        .clr_err   (clr_err)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a pop seen before an edge must show the next queued byte after it
    initial begin : monitor
        logic pop_seen;
        logic [7:0] exp;
        pop_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (pop_seen) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got %0h expected no byte", uart_data);
                end else begin
                    exp = exp_q.pop_front();
                    check("uart_data", {24'h0, uart_data}, {24'h0, exp});
                end
            end
            pop_seen = uart_re && !empty && !rst;
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input logic par_bit, input bit chk);
        logic [11:0] bits;
        int e;
        bits = 12'hFFF;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        bits[9 + c_pb] = stop_bit;
        if (c_pb == 1) bits[9] = par_bit;
        e = 0;
        for (int b = 0; b < 10 + c_pb; b++) begin
            rx = bits[b];
            for (int k = 0; k < c_cpb; k++) begin
                tick();
                e++;
                if (chk && e == c_stop_edge)     check("empty_at_stop_sample", {31'h0, empty}, 32'd1);
                if (chk && e == c_stop_edge + 1) check("empty_after_push", {31'h0, empty}, 32'd0);
            end
        end
        rx = 1'b1;
        repeat (4) tick();
    endtask

    task automatic send_good(input logic [7:0] d);
        exp_q.push_back(d);
        send_frame(d, 1'b1, ^d, 1'b0);
    endtask

    task automatic read_one();
        uart_re = 1'b1;
        tick();
        uart_re = 1'b0;
        tick();
        tick();
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        tick();
    endtask

    initial begin : stim
        int wait_cnt;
        rst = 1'b1;
        rx = 1'b1;
        uart_re = 1'b0;
        clr_err = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_empty", {31'h0, empty}, 32'd1);
        check("reset_full", {31'h0, full}, 32'd0);
        check("reset_frame_err", {31'h0, frame_err}, 32'd0);
        check("reset_overrun", {31'h0, overrun}, 32'd0);
        check("reset_uart_data", {24'h0, uart_data}, 32'h00);

        // Single frame with exact push timing
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        read_one();
        check("empty_after_read", {31'h0, empty}, 32'd1);

        // Fill past depth: fifth byte dropped
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, ^(8'(i)), 1'b0);
        end
        check("full_after_5", {31'h0, full}, 32'd1);
        check("overrun_after_5", {31'h0, overrun}, 32'd1);
        for (int i = 0; i < 4; i++) read_one();
        check("empty_after_drain", {31'h0, empty}, 32'd1);
        check("full_after_drain", {31'h0, full}, 32'd0);
        read_one();
        check("data_hold_on_empty_read", {24'h0, uart_data}, 32'h04);
        pulse_clr();
        check("overrun_cleared", {31'h0, overrun}, 32'd0);

        // Bad stop bit
        send_frame(8'h3C, 1'b0, ^(8'h3C), 1'b0);
        check("frame_err_set", {31'h0, frame_err}, 32'd1);
        check("empty_after_bad_stop", {31'h0, empty}, 32'd1);
        pulse_clr();
        check("frame_err_cleared", {31'h0, frame_err}, 32'd0);

        // Short glitch on rx
        rx = 1'b0;
        repeat (4) tick();
        rx = 1'b1;
        repeat (2 * c_cpb) tick();
        check("glitch_empty", {31'h0, empty}, 32'd1);
        check("glitch_frame_err", {31'h0, frame_err}, 32'd0);
        send_good(8'h7E);
        read_one();

        // Reset in the middle of bit 3 of 0x99
        rx = 1'b0;
        repeat (c_cpb) tick();
        for (int i = 0; i < 3; i++) begin
            rx = (8'h99 >> i) & 8'h01;
            repeat (c_cpb) tick();
        end
        rx = 1'b1;
        repeat (c_cpb / 2) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (3 * c_cpb) tick();
        check("rst_mid_empty", {31'h0, empty}, 32'd1);
        check("rst_mid_frame_err", {31'h0, frame_err}, 32'd0);
        check("rst_mid_uart_data", {24'h0, uart_data}, 32'h00);
        send_good(8'h42);
        read_one();

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        check("parity_err_set", {31'h0, parity_err}, 32'd1);
        check("parity_bad_empty", {31'h0, empty}, 32'd1);
        pulse_clr();
        check("parity_err_cleared", {31'h0, parity_err}, 32'd0);
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        read_one();
`endif

        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 50) begin
            tick();
            wait_cnt++;
        end
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit, minimum 4, even.
REQ-002 Parameter FIFO_DEPTH, default 4, receive FIFO entries, power of two, 2..16.
REQ-003 Port clk  input  1  single system clock; all logic updates on the rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port rx  input  1  asynchronous serial line, 8N1 frame, idle high, LSB first.
REQ-006 Port uart_re  input  1  consumer read strobe; pops one byte.
REQ-007 Port uart_data  output  8  registered byte most recently popped.
REQ-008 Port empty  output  1  high when the FIFO holds zero bytes.
REQ-009 Port full  output  1  high when the FIFO holds FIFO_DEPTH bytes.
REQ-010 Port frame_err  output  1  sticky; a frame was received with stop bit 0.
REQ-011 Port overrun  output  1  sticky; a valid byte was dropped because the FIFO was full.
REQ-012 Port clr_err  input  1  clears frame_err, overrun and parity_err on the next edge.

Function
REQ-013 rx shall pass through a two-flop synchronizer whose flops reset to 1; all sampling shall use the synchronized value.
REQ-014 The receiver FSM shall have states IDLE, START, DATA, STOP, plus PARITY when PARITY_EN is defined.
REQ-015 IDLE: a synchronized rx of 0 shall move the FSM to START and clear the bit-timer.
REQ-016 START: at timer count CLKS_PER_BIT/2-1, rx=0 shall go to DATA and restart the timer; rx=1 shall return to IDLE as a glitch, with no flag set.
REQ-017 DATA: rx shall be sampled every CLKS_PER_BIT cycles (mid-bit) into shift bits 0..7, LSB first; after bit 7, the FSM shall go to STOP (or PARITY).
REQ-018 STOP: at the mid-bit sample, rx=1 shall request a push of the byte; rx=0 shall set frame_err and discard the byte; in both cases the FSM shall return to IDLE on the same edge.
REQ-019 The push shall write the FIFO on the edge following the stop sample; empty shall deassert on that same edge.
REQ-020 A push while full with no simultaneous pop shall discard the byte, set overrun, and leave the FIFO unchanged.
REQ-021 uart_re with empty low shall load the head byte into uart_data and advance the read pointer on the same edge (1-cycle read latency).
REQ-022 uart_re with empty high shall be ignored; uart_data shall hold its value.
REQ-023 Simultaneous push and pop shall both take effect and keep the count unchanged; when full, this shall not set overrun.
REQ-024 The read and write pointers shall wrap modulo FIFO_DEPTH; the count shall be width clog2(FIFO_DEPTH)+1.
REQ-025 clr_err coinciding with a new error event shall leave the flag set (the set wins).

Reset
REQ-026 Reset shall apply on a clk edge with rst=1: FSM to IDLE, timer/bit index to 0, pointers/count to 0, uart_data=0x00, empty=1, full=0, all error flags 0, synchronizer to 1.
REQ-027 Reset asserted mid-frame shall abandon the frame with no push and no flag; reception shall resume on the next falling rx edge after rst=0.

Configuration
REQ-028 Macro UART_RX_PARITY_EN: when defined, the frame shall be 8E1, a PARITY state shall sample one even-parity bit after bit 7, and an output parity_err (1 bit, sticky) shall exist; a mismatch shall set parity_err and discard the byte, while the stop bit shall still be checked.
REQ-029 Without UART_RX_PARITY_EN, the frame shall be 8N1, with no PARITY state and no parity_err port.

Verification
REQ-030 Frame 0xA5 on rx, CLKS_PER_BIT=16 -> empty falls one cycle after the stop mid-sample; one uart_re gives uart_data=0xA5 next edge, empty=1.
REQ-031 Five bytes 0x01..0x05 sent with no reads, depth 4 -> full=1, overrun=1; four reads give 0x01..0x04 in order, then empty=1.
REQ-032 Frame 0x3C with stop bit 0 -> frame_err=1, empty stays 1; clr_err pulse -> frame_err=0.
REQ-033 rx low for 4 cycles then high -> FSM returns to IDLE, no push, no flags; a following frame 0x7E is received correctly.
REQ-034 rst pulsed during bit 3 of 0x99 -> no byte stored; the next frame 0x42 reads back 0x42.
REQ-035 UART_RX_PARITY_EN defined, 0x07 sent with parity bit 0 (wrong) -> parity_err=1, FIFO empty; 0x07 with parity 1 -> stored, reads 0x07.
